mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
- REQ-001: Parameter DATA_W, default 32: data width of all data buses.
- REQ-002: Parameter ADDR_W, default 32: address width of all address buses.
- REQ-003: Parameter MAX_BURST, default 16: maximum camera beats per grant.
- REQ-004: clk  in  1  sole clock, rising edge.
- REQ-005: reset  in  1  asynchronous, active-low reset.
- REQ-006: cpu_req  in  1  CPU data-memory request, held until cpu_ack.
- REQ-007: cpu_we  in  1  CPU write (1) / read (0).
- REQ-008: cpu_addr  in  ADDR_W  CPU byte address.
- REQ-009: cpu_wdata  in  DATA_W  CPU write data.
- REQ-010: cpu_rdata  out  DATA_W  read data, valid while cpu_ack=1 on a read.
- REQ-011: cpu_ack  out  1  one-cycle completion pulse.
- REQ-012: cpu_stall  out  1  pipeline stall, equal to cpu_req & ~cpu_ack.
- REQ-013: cam_req  in  1  camera write beat valid.
- REQ-014: cam_addr  in  ADDR_W  camera beat address.
- REQ-015: cam_wdata  in  DATA_W  camera pixel word.
- REQ-016: cam_last  in  1  final beat of the frame line.
- REQ-017: cam_ack  out  1  beat accepted this cycle.
- REQ-018: mem_en, mem_we  out  1 each  RAM port strobe and write enable.
- REQ-019: mem_addr  out  ADDR_W; mem_wdata  out  DATA_W  RAM port address and write data.
- REQ-020: mem_rdata  in  DATA_W  RAM read data, valid one cycle after a read strobe.

Function
- REQ-021: The FSM SHALL have exactly four states: IDLE, CPU_ACC, CPU_RDW, CAM_BURST.
- REQ-022: IDLE behaviour:
  - all strobes and acks = 0;
  - only cpu_req -> CPU_ACC; only cam_req -> CAM_BURST; neither -> stay in IDLE;
  - both -> grant the requester not granted last (round-robin bit last_cam).
- REQ-023: CPU_ACC behaviour:
  - mem_en=1, mem_we=cpu_we, mem_addr=cpu_addr, mem_wdata=cpu_wdata;
  - write: cpu_ack=1 in this cycle, next state IDLE;
  - read: next state CPU_RDW.
- REQ-024: CPU_RDW SHALL drive cpu_rdata=mem_rdata, cpu_ack=1 and mem_en=0, with next state IDLE.
- REQ-025: CPU access latency, measured from the IDLE grant cycle: write acks 1 cycle later, read acks 2 cycles later.
- REQ-026: CAM_BURST behaviour:
  - mem_en=cam_req, mem_we=1, mem_addr=cam_addr, mem_wdata=cam_wdata, cam_ack=cam_req (combinational);
  - the beat counter increments on each accepted beat.
- REQ-027: CAM_BURST exit: go to IDLE after an accepted beat with cam_last=1, or after the accepted beat that brings the counter to MAX_BURST; the counter clears on exit.
- REQ-028: In CAM_BURST, cycles with cam_req=0 SHALL hold state and counter, with no timeout.
- REQ-029: last_cam SHALL be set to 1 on entry to CAM_BURST and cleared to 0 on entry to CPU_ACC.
- REQ-030: cam_ack SHALL be 0 in every state other than CAM_BURST; cpu_ack SHALL be 0 in every state other than CPU_ACC (writes only) and CPU_RDW.
- REQ-031: The beat counter width SHALL be $clog2(MAX_BURST+1) and it SHALL never wrap.
- REQ-032: A CPU request arriving mid-burst SHALL wait at most MAX_BURST accepted beats plus one IDLE cycle.

Reset
- REQ-033: While reset=0, asynchronously:
  - state=IDLE, counter=0, last_cam=1 (CPU wins the first tie);
  - all outputs 0, including cpu_rdata.
- REQ-034: A reset asserted mid-burst or mid-read SHALL abandon the transaction: no ack is issued and no strobe is generated in the reset cycle.

Structure
- REQ-035: Package mem_arb_pkg SHALL hold the state enum type arb_state_t and the default width and burst constants.
- REQ-036: One sub-module, arb_beat_counter (clear, increment, MAX_BURST compare), SHALL be instantiated; all other logic stays in mem_arbiter.

Verification
- REQ-037: Test CPU write only.
  - Stimulus: cpu_req=1, cpu_we=1, addr 0x40, data 0xDEADBEEF.
  - Response: mem_we pulses 1 cycle after the request is sampled; cpu_ack coincides with it; cpu_stall=1 for 1 cycle.
- REQ-038: Test CPU read only.
  - Stimulus: RAM word 0x40 = 0x12345678.
  - Response: cpu_ack arrives 2 cycles after grant with cpu_rdata=0x12345678.
- REQ-039: Test tie after reset.
  - Stimulus: cpu_req and cam_req both rise together after reset.
  - Response: CPU is served first, then CAM_BURST; on the next tie the camera wins.
- REQ-040: Test burst cap.
  - Stimulus: 20 continuous camera beats with no cam_last, and cpu_req pending.
  - Response: exactly 16 cam_acks, then the CPU access, then the remaining 4 beats.
- REQ-041: Test gapped burst.
  - Stimulus: camera burst of 5 beats with cam_req gaps, cam_last on beat 5.
  - Response: counter holds during gaps; state returns to IDLE after beat 5.
- REQ-042: Test reset mid-burst.
  - Stimulus: reset asserted after beat 3.
  - Response: outputs go to 0 immediately; after release the state is IDLE with counter=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the CPU/camera memory arbiter.
package mem_arb_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int ADDR_W_DEF    = 32;
  localparam int MAX_BURST_DEF = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CPU_ACC   = 2'd1,
    CPU_RDW   = 2'd2,
    CAM_BURST = 2'd3
  } arb_state_t;

endpackage

// File: rtl/arb_beat_counter.sv
// Counts accepted camera beats within one grant; flags the beat that reaches the cap.
module arb_beat_counter
  import mem_arb_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF,
  localparam int CNT_W    = $clog2(MAX_BURST + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic at_last
);

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  // next count: clear wins, increment saturates so the counter can never wrap
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q < CNT_W'(MAX_BURST))) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign at_last = (count_q == CNT_W'(MAX_BURST - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between a CPU data port and a camera write-burst stream,
// with round-robin tie breaking and a capped camera burst length.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              cam_req,
  input  logic [ADDR_W-1:0] cam_addr,
  input  logic [DATA_W-1:0] cam_wdata,
  input  logic              cam_last,
  output logic              cam_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t state_d, state_q;
  logic       last_cam_d, last_cam_q;
  logic       beat_acc_s;
  logic       burst_end_s;
  logic       at_last_s;

  assign beat_acc_s  = (state_q == CAM_BURST) && cam_req;
  assign burst_end_s = beat_acc_s && (cam_last || at_last_s);

  arb_beat_counter #(
    .MAX_BURST (MAX_BURST)
  ) u_beat_counter (
    .clk     (clk),
    .reset   (reset),
    .clr     (burst_end_s),
    .inc     (beat_acc_s),
    .at_last (at_last_s)
  );

  // next state and round-robin bookkeeping; last_cam=1 hands the next tie to the CPU
  always_comb begin
    state_d    = state_q;
    last_cam_d = last_cam_q;
    case (state_q)
      IDLE: begin
        if (cpu_req && (!cam_req || last_cam_q)) begin
          state_d    = CPU_ACC;
          last_cam_d = 1'b0;
        end else if (cam_req) begin
          state_d    = CAM_BURST;
          last_cam_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      CPU_ACC: begin
        if (cpu_we) begin
          state_d = IDLE;
        end else begin
          state_d = CPU_RDW;
        end
      end
      CPU_RDW: state_d = IDLE;
      CAM_BURST: begin
        if (burst_end_s) begin
          state_d = IDLE;
        end else begin
          state_d = CAM_BURST;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      last_cam_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_cam_q <= last_cam_d;
    end
  end

  // RAM port and handshake decode; IDLE (and therefore reset) drives everything low
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_ack   = 1'b0;
    cpu_rdata = '0;
    cam_ack   = 1'b0;
    case (state_q)
      CPU_ACC: begin
        mem_en    = 1'b1;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        cpu_ack   = cpu_we;
      end
      CPU_RDW: begin
        cpu_ack   = 1'b1;
        cpu_rdata = mem_rdata;
      end
      CAM_BURST: begin
        mem_en    = cam_req;
        mem_we    = 1'b1;
        mem_addr  = cam_addr;
        mem_wdata = cam_wdata;
        cam_ack   = cam_req;
      end
      default: begin
        mem_en = 1'b0;
      end
    endcase
  end

  // stall is forced low while reset is asserted so every output reads 0
  assign cpu_stall = reset & cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed latency/arbitration cases plus a
// randomized run against a transaction-level memory and fairness model.
module tb_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MB = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, cpu_ack, cpu_stall;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cam_req, cam_last, cam_ack;
  logic [AW-1:0] cam_addr;
  logic [DW-1:0] cam_wdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .cam_req(cam_req), .cam_addr(cam_addr), .cam_wdata(cam_wdata), .cam_last(cam_last),
    .cam_ack(cam_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // environment RAM: one-cycle read latency
  logic          ram_clear;
  logic [31:0]   ram [0:255];
  logic [31:0]   ram_rdata_r;
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'd0;
    end else begin
      if (mem_en && mem_we)  ram[mem_addr[9:2]] <= mem_wdata;
      if (mem_en && !mem_we) ram_rdata_r <= ram[mem_addr[9:2]];
    end
  end
  assign mem_rdata = ram_rdata_r;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
    cam_req = 1'b0; cam_addr = 32'd0; cam_wdata = 32'd0; cam_last = 1'b0;
  endtask

  task automatic do_reset();
    tick(); idle_inputs(); reset = 1'b0;
    tick(); tick(); reset = 1'b1;
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    bit got;
    tick(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d; settle();
    got = cpu_ack;
    for (int k = 0; k < 40 && !got; k++) begin tick(); settle(); got = cpu_ack; end
    check_val("cpu_write_ack", 32'(got), 32'd1);
    tick(); cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  // 20 back-to-back camera beats with a CPU write raised one cycle later
  task automatic run_cap(input logic [31:0] base, output int at_cpu, output int total, output int lat);
    int c16, ccpu;
    bit done;
    total = 0; at_cpu = -1; c16 = 0; ccpu = -100; done = 1'b0;
    for (int cyc = 0; cyc < 200 && !(total == 20 && done); cyc++) begin
      tick();
      cam_req = (total < 20); cam_addr = base + 32'(total * 4);
      cam_wdata = 32'hCA000000 + 32'(total); cam_last = 1'b0;
      cpu_req = (cyc >= 1) && !done; cpu_we = 1'b1; cpu_addr = 32'h80; cpu_wdata = 32'h0BADF00D;
      settle();
      if (cam_ack) begin total++; if (total == 16) c16 = cyc; end
      if (cpu_ack) begin at_cpu = total; done = 1'b1; ccpu = cyc; end
    end
    lat = ccpu - c16;
    tick(); idle_inputs();
  endtask

  logic [31:0] ref_mem [0:63];
  logic        c_we, k_last;
  logic [31:0] c_addr, c_data, k_addr, k_data;
  bit          cpu_busy, cam_pend, gap_next, gap_now;
  int          burst_beats, c_wait_beats, c_wait_cyc, cam_ptr, n_cpu, n_cam;
  int          at_cpu, total, lat, beats;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs(); reset = 1'b0; ram_clear = 1'b1;
    tick(); tick();
    cpu_req = 1'b1; cam_req = 1'b1; settle();
    check_val("rst_mem_en", 32'(mem_en), 32'd0);
    check_val("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check_val("rst_cam_ack", 32'(cam_ack), 32'd0);
    check_val("rst_cpu_stall", 32'(cpu_stall), 32'd0);
    check_val("rst_cpu_rdata", cpu_rdata, 32'd0);
    idle_inputs(); ram_clear = 1'b0; reset = 1'b1;

    // CPU write
    tick(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'hDEADBEEF; settle();
    check_val("wr_stall_grant", 32'(cpu_stall), 32'd1);
    check_val("wr_no_strobe_grant", 32'(mem_en), 32'd0);
    tick(); settle();
    check_val("wr_mem_we", 32'(mem_we), 32'd1);
    check_val("wr_mem_en", 32'(mem_en), 32'd1);
    check_val("wr_cpu_ack", 32'(cpu_ack), 32'd1);
    check_val("wr_stall_ack", 32'(cpu_stall), 32'd0);
    check_val("wr_mem_addr", mem_addr, 32'h40);
    check_val("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
    tick(); idle_inputs(); settle();
    check_val("wr_idle_after", 32'(mem_en | cpu_ack), 32'd0);

    // CPU read
    cpu_write(32'h40, 32'h12345678);
    tick(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; settle();
    check_val("rd_stall_grant", 32'(cpu_stall), 32'd1);
    tick(); settle();
    check_val("rd_no_ack_acc", 32'(cpu_ack), 32'd0);
    check_val("rd_strobe_acc", 32'({mem_en, mem_we}), 32'd2);
    tick(); settle();
    check_val("rd_ack", 32'(cpu_ack), 32'd1);
    check_val("rd_rdata", cpu_rdata, 32'h12345678);
    check_val("rd_no_strobe_rdw", 32'(mem_en), 32'd0);
    tick(); idle_inputs(); settle();
    check_val("rd_rdata_cleared", cpu_rdata, 32'd0);

    // tie after reset, then tie with CPU granted last
    do_reset();
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h80; cpu_wdata = 32'hA5A5A5A5;
    cam_req = 1'b1; cam_addr = 32'h100; cam_wdata = 32'h00C0FFEE; cam_last = 1'b1; settle();
    check_val("tie1_idle_acks", 32'({cpu_ack, cam_ack}), 32'd0);
    tick(); settle();
    check_val("tie1_cpu_first", 32'({cpu_ack, cam_ack}), 32'd2);
    tick(); cpu_addr = 32'h84; cpu_wdata = 32'h11111111; settle();
    check_val("tie2_idle_acks", 32'({cpu_ack, cam_ack}), 32'd0);
    tick(); settle();
    check_val("tie2_cam_wins", 32'({cpu_ack, cam_ack}), 32'd1);
    check_val("tie2_cam_addr", mem_addr, 32'h100);
    tick(); cam_req = 1'b0; settle();
    check_val("tie2_idle_gap", 32'({cpu_ack, cam_ack}), 32'd0);
    tick(); settle();
    check_val("tie2_cpu_after", 32'(cpu_ack), 32'd1);
    check_val("tie2_cpu_addr", mem_addr, 32'h84);
    tick(); idle_inputs();

    // gapped burst of 5 beats
    beats = 0;
    for (int cyc = 0; cyc < 60 && beats < 5; cyc++) begin
      tick();
      cam_req = (cyc % 3 != 1); cam_addr = 32'h200 + 32'(beats * 4);
      cam_wdata = 32'h5A000000 + 32'(beats); cam_last = (beats == 4);
      settle();
      if (!cam_req) check_val("gap_hold_no_ack", 32'(cam_ack), 32'd0);
      if (cam_ack) begin
        check_val("gap_beat_addr", mem_addr, 32'h200 + 32'(beats * 4));
        beats++;
      end
    end
    check_val("gap_beat_count", 32'(beats), 32'd5);
    tick(); cam_req = 1'b1; cam_last = 1'b1; cam_addr = 32'h300; settle();
    check_val("gap_exit_idle", 32'(cam_ack), 32'd0);
    tick(); settle();
    check_val("gap_regrant", 32'(cam_ack), 32'd1);
    tick(); idle_inputs();

    // burst cap with CPU pending
    run_cap(32'h200, at_cpu, total, lat);
    check_val("cap_beats_before_cpu", 32'(at_cpu), 32'd16);
    check_val("cap_total_beats", 32'(total), 32'd20);
    check_val("cap_cpu_latency", 32'(lat), 32'd2);

    // reset mid-burst after beat 3
    do_reset();
    beats = 0;
    for (int cyc = 0; cyc < 20 && beats < 3; cyc++) begin
      tick(); cam_req = 1'b1; cam_addr = 32'h240 + 32'(beats * 4); cam_wdata = 32'h77; settle();
      if (cam_ack) beats++;
    end
    check_val("rstb_beats", 32'(beats), 32'd3);
    tick(); reset = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; settle();
    check_val("rstb_cam_ack", 32'(cam_ack), 32'd0);
    check_val("rstb_strobes", 32'({mem_en, mem_we}), 32'd0);
    check_val("rstb_cpu", 32'({cpu_ack, cpu_stall}), 32'd0);
    check_val("rstb_mem_addr", mem_addr, 32'd0);
    tick(); reset = 1'b1; idle_inputs();
    run_cap(32'h280, at_cpu, total, lat);
    check_val("rstb_counter_cleared", 32'(at_cpu), 32'd16);

    // reset during the read-data cycle
    do_reset();
    tick(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    tick(); tick(); reset = 1'b0; settle();
    check_val("rstr_no_ack", 32'(cpu_ack), 32'd0);
    check_val("rstr_rdata", cpu_rdata, 32'd0);
    tick(); reset = 1'b1; idle_inputs();

    // randomized traffic against a memory/fairness model
    do_reset();
    ram_clear = 1'b1; tick(); ram_clear = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;
    cpu_busy = 1'b0; cam_pend = 1'b0; gap_next = 1'b0; burst_beats = 0; cam_ptr = 0;
    n_cpu = 0; n_cam = 0; c_we = 1'b0; c_addr = 32'd0; c_data = 32'd0;
    k_addr = 32'd0; k_data = 32'd0; k_last = 1'b0; c_wait_beats = 0; c_wait_cyc = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (!cpu_busy && $urandom_range(0, 3) == 0) begin
        cpu_busy = 1'b1; c_we = 1'($urandom_range(0, 1));
        c_addr = 32'($urandom_range(0, 63)) << 2; c_data = $urandom();
        c_wait_beats = 0; c_wait_cyc = 0;
      end
      cpu_req = cpu_busy; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_data;
      if (!cam_pend && $urandom_range(0, 1) == 0) begin
        cam_pend = 1'b1; k_addr = 32'(cam_ptr) << 2; k_data = $urandom();
        k_last = ($urandom_range(0, 11) == 0); cam_ptr = (cam_ptr + 1) % 64;
      end
      cam_req = cam_pend && ($urandom_range(0, 3) != 0);
      cam_addr = k_addr; cam_wdata = k_data; cam_last = k_last;
      settle();
      gap_now = 1'b0;
      check_val("rnd_ack_excl", 32'(cpu_ack & cam_ack), 32'd0);
      check_val("rnd_cam_ack_wo_req", 32'(cam_ack & ~cam_req), 32'd0);
      check_val("rnd_cpu_ack_wo_req", 32'(cpu_ack & ~cpu_req), 32'd0);
      if (gap_next) check_val("rnd_burst_gap", 32'(cam_ack), 32'd0);
      if (cam_ack) begin
        check_val("rnd_cam_strobe", 32'({mem_en, mem_we}), 32'd3);
        check_val("rnd_cam_addr", mem_addr, k_addr);
        check_val("rnd_cam_wdata", mem_wdata, k_data);
        ref_mem[k_addr[7:2]] = k_data;
        burst_beats++;
        if (cpu_busy) c_wait_beats++;
        if (k_last || burst_beats == MB) begin burst_beats = 0; gap_now = 1'b1; end
        cam_pend = 1'b0; n_cam++;
      end
      if (cpu_ack) begin
        check_val("rnd_cpu_wait_beats", 32'(c_wait_beats <= MB), 32'd1);
        check_val("rnd_cpu_min_lat", 32'(c_wait_cyc >= (c_we ? 1 : 2)), 32'd1);
        if (c_we) begin
          check_val("rnd_wr_addr", mem_addr, c_addr);
          check_val("rnd_wr_data", mem_wdata, c_data);
          ref_mem[c_addr[7:2]] = c_data;
        end else begin
          check_val("rnd_rdata", cpu_rdata, ref_mem[c_addr[7:2]]);
        end
        cpu_busy = 1'b0; n_cpu++;
      end else if (cpu_busy) begin
        c_wait_cyc++;
      end
      gap_next = gap_now;
    end
    check_val("rnd_cpu_progress", 32'(n_cpu > 100), 32'd1);
    check_val("rnd_cam_progress", 32'(n_cam > 300), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
